pc_seq: RTL and testbench

//   Parametrised program counter for the 8-bit CPU datapath. Drives the fetch address into

---
 rtl/cpu_pkg.sv | 15 +
 rtl/pc_ras.sv | 64 ++++++
 rtl/pc_seq.sv | 71 +++++++
 tb/tb_pc_seq.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: address defaults and the next-PC source select.
package cpu_pkg;
    localparam int ADDR_W_DEF    = 8;
    localparam int RESET_PC_DEF  = 0;
    localparam int RAS_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_BR,
        PC_JMP,
        PC_CALL,
        PC_RET
    } pc_sel_t;
endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push when full overwrites the oldest entry.
// A pop when empty leaves the stack alone. Both cases set the sticky error flag.
module pc_ras #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top_data,
    output logic         full,
    output logic         empty,
    output logic         err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [PTR_W-1:0] top_idx;

    // ptr_q is the next free slot, so the top entry sits one below it.
    assign top_idx  = ptr_q - PTR_W'(1);
    assign top_data = mem_q[top_idx];
    assign full     = (cnt_q == CNT_W'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign err      = err_q;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        err_d = err_q;
        if (push) begin
            ptr_d = ptr_q + PTR_W'(1);
            if (full) err_d = 1'b1;
            else      cnt_d = cnt_q + CNT_W'(1);
        end else if (pop) begin
            if (empty) begin
                err_d = 1'b1;
            end else begin
                ptr_d = top_idx;
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
            mem_q <= '{default: '0};
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
            if (push) mem_q[ptr_q] <= push_data;
        end
    end
endmodule

// File: rtl/pc_seq.sv
// Program counter sequencer: priority-encoded next-PC select, next-PC mux, PC register,
// and a return-address stack for call/return.
module pc_seq
    import cpu_pkg::*;
#(
    parameter int                ADDR_W    = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(RESET_PC_DEF),
    parameter int                RAS_DEPTH = RAS_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              branch_en,
    input  logic [ADDR_W-1:0] branch_off,
    input  logic              jump_en,
    input  logic              call_en,
    input  logic              ret_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_next,
    output logic              ras_full,
    output logic              ras_empty,
    output logic              ras_err
);
    pc_sel_t           sel;
    logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, ras_top;

    assign pc_inc = pc_q + ADDR_W'(1);

    always_comb begin
        sel = PC_INC;
        if      (stall)     sel = PC_HOLD;
        else if (ret_en)    sel = PC_RET;
        else if (call_en)   sel = PC_CALL;
        else if (jump_en)   sel = PC_JMP;
        else if (branch_en) sel = PC_BR;
    end

    always_comb begin
        pc_d = pc_inc;
        case (sel)
            PC_HOLD:         pc_d = pc_q;
            PC_INC:          pc_d = pc_inc;
            PC_BR:           pc_d = pc_q + branch_off;
            PC_JMP, PC_CALL: pc_d = jump_addr;
            // Return with nothing on the stack just falls through to the next instruction.
            PC_RET:          pc_d = ras_empty ? pc_inc : ras_top;
            default:         pc_d = pc_inc;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pc_q <= RESET_PC;
        else     pc_q <= pc_d;
    end

    pc_ras #(.W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (sel == PC_CALL),
        .pop       (sel == PC_RET),
        .push_data (pc_inc),
        .top_data  (ras_top),
        .full      (ras_full),
        .empty     (ras_empty),
        .err       (ras_err)
    );

    assign pc      = pc_q;
    assign pc_next = pc_d;
endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: queue-based reference model checked every cycle, plus directed literal checks.
module tb_pc_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0, branch_en = 1'b0, jump_en = 1'b0, call_en = 1'b0, ret_en = 1'b0;
    logic [7:0] branch_off = '0, jump_addr = '0;
    logic [7:0] pc, pc_next;
    logic       ras_full, ras_empty, ras_err;

    int vectors = 0;
    int miscompares = 0;

    pc_seq dut (
        .clk(clk), .rst(rst), .stall(stall), .branch_en(branch_en), .branch_off(branch_off),
        .jump_en(jump_en), .call_en(call_en), .ret_en(ret_en), .jump_addr(jump_addr),
        .pc(pc), .pc_next(pc_next), .ras_full(ras_full), .ras_empty(ras_empty), .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    // Reference model: PC as a number, return stack as a queue (back = newest).
    logic [7:0] m_pc = '0;
    logic [7:0] m_q[$];
    logic       m_err = 1'b0;

    function automatic logic [7:0] exp_next();
        if (stall)              return m_pc;
        if (ret_en)             return (m_q.size() > 0) ? m_q[$] : 8'(m_pc + 8'd1);
        if (call_en || jump_en) return jump_addr;
        if (branch_en)          return 8'(m_pc + branch_off);
        return 8'(m_pc + 8'd1);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pc = '0;
            m_q.delete();
            m_err = 1'b0;
        end else begin
            logic [7:0] nxt;
            nxt = exp_next();
            if (!stall) begin
                if (ret_en) begin
                    if (m_q.size() > 0) void'(m_q.pop_back());
                    else                m_err = 1'b1;
                end else if (call_en) begin
                    if (m_q.size() == 4) begin
                        void'(m_q.pop_front());
                        m_err = 1'b1;
                    end
                    m_q.push_back(8'(m_pc + 8'd1));
                end
            end
            m_pc = nxt;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("pc",        32'(pc),        32'(m_pc));
            chk("pc_next",   32'(pc_next),   32'(exp_next()));
            chk("ras_full",  32'(ras_full),  32'(m_q.size() == 4));
            chk("ras_empty", 32'(ras_empty), 32'(m_q.size() == 0));
            chk("ras_err",   32'(ras_err),   32'(m_err));
        end
    end

    task automatic idle();
        stall = 0; branch_en = 0; jump_en = 0; call_en = 0; ret_en = 0;
        branch_off = '0; jump_addr = '0;
    endtask

    // Drive one set of controls across one rising edge, then return to idle.
    task automatic step(input logic s, input logic br, input logic [7:0] off,
                        input logic j, input logic c, input logic r, input logic [7:0] a);
        stall = s; branch_en = br; branch_off = off; jump_en = j; call_en = c; ret_en = r;
        jump_addr = a;
        @(posedge clk); #2;
        idle();
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Reset and plain increment
        chk("rst_pc", 32'(pc), 32'h00);
        chk("rst_empty", 32'(ras_empty), 1);
        chk("rst_err", 32'(ras_err), 0);
        step(0, 0, 0, 0, 0, 0, 0); chk("inc1", 32'(pc), 32'h01);
        step(0, 0, 0, 0, 0, 0, 0); chk("inc2", 32'(pc), 32'h02);

        // Wrap-around and signed branches
        do_reset();
        repeat (255) step(0, 0, 0, 0, 0, 0, 0);
        chk("wrap_ff", 32'(pc), 32'hFF);
        step(0, 0, 0, 0, 0, 0, 0); chk("wrap_00", 32'(pc), 32'h00);
        step(0, 0, 0, 1, 0, 0, 8'h01);
        step(0, 1, 8'hFE, 0, 0, 0, 0); chk("br_back", 32'(pc), 32'hFF);
        step(0, 0, 0, 1, 0, 0, 8'hFD);
        step(0, 1, 8'h05, 0, 0, 0, 0); chk("br_wrap", 32'(pc), 32'h02);

        // Single call/return
        step(0, 0, 0, 1, 0, 0, 8'h10);
        step(0, 0, 0, 0, 1, 0, 8'h40); chk("call_pc", 32'(pc), 32'h40);
        step(0, 0, 0, 0, 0, 1, 0);     chk("ret_pc", 32'(pc), 32'h11);
        chk("ret_empty", 32'(ras_empty), 1);

        // Overflow then drain
        do_reset();
        step(0, 0, 0, 1, 0, 0, 8'h20);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 0, 8'(8'h30 + 8'(i * 16)));
        chk("ovf_err", 32'(ras_err), 1);
        chk("ovf_full", 32'(ras_full), 1);
        step(0, 0, 0, 0, 0, 1, 0); chk("pop61", 32'(pc), 32'h61);
        step(0, 0, 0, 0, 0, 1, 0); chk("pop51", 32'(pc), 32'h51);
        step(0, 0, 0, 0, 0, 1, 0); chk("pop41", 32'(pc), 32'h41);
        step(0, 0, 0, 0, 0, 1, 0); chk("pop31", 32'(pc), 32'h31);
        step(0, 0, 0, 0, 0, 1, 0); chk("unf_pc", 32'(pc), 32'h32);
        chk("unf_err", 32'(ras_err), 1);

        // Priority and stall
        do_reset();
        step(0, 0, 0, 1, 0, 0, 8'h50);
        step(0, 0, 0, 0, 1, 0, 8'h60);
        step(0, 0, 0, 1, 1, 1, 8'h90); chk("prio_ret", 32'(pc), 32'h51);
        stall = 1; jump_en = 1; jump_addr = 8'hAA;
        #1 chk("stall_next", 32'(pc_next), 32'h51);
        @(posedge clk); #2 idle();
        chk("stall_pc", 32'(pc), 32'h51);
        chk("stall_empty", 32'(ras_empty), 1);

        // Async reset mid call sequence, with the error flag set beforehand
        do_reset();
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0, 8'h30);
        step(0, 0, 0, 0, 1, 0, 8'h40);
        chk("pre_err", 32'(ras_err), 1);
        #1 rst = 1'b1;
        #1 chk("arst_pc", 32'(pc), 32'h00);
        chk("arst_empty", 32'(ras_empty), 1);
        chk("arst_err", 32'(ras_err), 0);
        @(posedge clk); #2 rst = 1'b0;

        // Randomized controls, including occasional mid-cycle reset pulses
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                rst = 1'b1;
                #1 rst = 1'b0;
            end
            stall      = ($urandom_range(0, 99) < 10);
            ret_en     = ($urandom_range(0, 99) < 20);
            call_en    = ($urandom_range(0, 99) < 25);
            jump_en    = ($urandom_range(0, 99) < 10);
            branch_en  = ($urandom_range(0, 99) < 20);
            branch_off = 8'($urandom);
            jump_addr  = 8'($urandom);
            @(posedge clk); #2;
        end
        idle();
        @(posedge clk); #2;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
